// File: rtl/controle_medicao_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 measurement sequencer.
//   - estado_t: FSM state encodings (each encoding equals its debug display code)
//   - BCD_W: width of a 3-digit BCD distance
//   - LIMITE_TIMEOUTS: saturation value of the timeout diagnostic counter
//   - largura(): counter width needed to count 0..m-1
//   - codigo_db(): state to 7-segment debug code (unused encodings show F)
package controle_medicao_hcsr04_pkg;

    localparam int BCD_W          = 12;
    localparam int CONT_TIMEOUT_W = 4;

    localparam logic [CONT_TIMEOUT_W-1:0] LIMITE_TIMEOUTS = 4'd15;
    localparam logic [3:0]                DB_INVALIDO     = 4'hF;

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        DISPARA          = 4'h1,
        ESPERA_PRONTO    = 4'h2,
        REGISTRA         = 4'h3,
        ESPERA_INTERVALO = 4'h4,
        FALHA            = 4'hE
    } estado_t;

    function automatic int largura(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [3:0] codigo_db(input estado_t e);
        logic [3:0] codigo;
        case (e)
            INICIAL, DISPARA, ESPERA_PRONTO, REGISTRA,
            ESPERA_INTERVALO, FALHA: codigo = 4'(e);
            default:                 codigo = DB_INVALIDO;
        endcase
        return codigo;
    endfunction

endpackage

// File: rtl/controle_medicao_hcsr04_if.sv
// Handshake between the measurement sequencer and the HC-SR04 interface.
//   medir         : one-cycle start request (sequencer -> interface)
//   pronto_sensor : one-cycle completion pulse (interface -> sequencer)
//   medida        : 3-digit BCD distance, valid from the pronto_sensor cycle on
// master = sequencer side, slave = sensor interface side.
interface controle_medicao_hcsr04_if;

    logic                                            medir;
    logic                                            pronto_sensor;
    logic [controle_medicao_hcsr04_pkg::BCD_W-1:0]   medida;

    modport master (
        output medir,
        input  pronto_sensor,
        input  medida
    );

    modport slave (
        input  medir,
        output pronto_sensor,
        output medida
    );

endinterface

// File: rtl/controle_medicao_hcsr04_contador_m.sv
// Modulo-M up counter.
//   clock, reset : clock and asynchronous active-high reset
//   zera         : synchronous clear (has priority over conta)
//   conta        : count enable; wraps from M-1 back to 0
//   Q            : current count
//   fim          : high while Q == M-1
module contador_m
    import controle_medicao_hcsr04_pkg::*;
#(
    parameter int M = 16,
    localparam int W = largura(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;

    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (conta) begin
            cont_d = fim ? '0 : cont_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign Q   = cont_q;
    assign fim = (cont_q == W'(M - 1));

endmodule

// File: rtl/controle_medicao_hcsr04.sv
// Periodic measurement sequencer for the HC-SR04 interface.
// Issues medir every INTERVALO cycles while ligar is high, waits up to TIMEOUT
// cycles for pronto_sensor, latches the BCD distance, drives a hysteretic
// proximity alarm and keeps timeout diagnostics.
//   clock, reset   : clock and asynchronous active-high reset
//   ligar          : level enable for periodic measurement
//   sensor         : handshake with the sensor interface (medir/pronto_sensor/medida)
//   medida_valida  : last captured BCD distance
//   nova_medida    : one-cycle pulse aligned with a freshly updated medida_valida
//   alerta         : set below LIMIAR_ON, cleared at or above LIMIAR_OFF
//   erro_timeout   : set by a timeout, cleared by the next capture
//   cont_timeouts  : saturating timeout count
//   db_estado      : state code for the debug display
module controle_medicao_hcsr04
    import controle_medicao_hcsr04_pkg::*;
#(
    parameter int                INTERVALO  = 5_000_000,
    parameter int                TIMEOUT    = 2_500_000,
    parameter logic [BCD_W-1:0]  LIMIAR_ON  = 12'h020,
    parameter logic [BCD_W-1:0]  LIMIAR_OFF = 12'h025
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ligar,
    controle_medicao_hcsr04_if.master  sensor,
    output logic [BCD_W-1:0]           medida_valida,
    output logic                       nova_medida,
    output logic                       alerta,
    output logic                       erro_timeout,
    output logic [CONT_TIMEOUT_W-1:0]  cont_timeouts,
    output logic [3:0]                 db_estado
);

    localparam int W_INTERVALO = largura(INTERVALO);
    localparam int W_TIMEOUT   = largura(TIMEOUT);

    estado_t estado_q;
    estado_t estado_d;

    logic [BCD_W-1:0]          medida_valida_q;
    logic [BCD_W-1:0]          medida_valida_d;
    logic                      alerta_q;
    logic                      alerta_d;
    logic                      erro_timeout_q;
    logic                      erro_timeout_d;
    logic [CONT_TIMEOUT_W-1:0] cont_timeouts_q;
    logic [CONT_TIMEOUT_W-1:0] cont_timeouts_d;

    logic                      fim_intervalo;
    logic                      fim_timeout;
    logic                      zera_intervalo;
    logic                      conta_timeout;
    logic                      zera_timeout;
    logic [W_INTERVALO-1:0]    q_intervalo_unused;
    logic [W_TIMEOUT-1:0]      q_timeout_unused;

    // The interval counter is cleared on the edge into dispara, so it reads 0
    // throughout dispara and the next dispara lands exactly INTERVALO cycles
    // after the previous one.
    assign zera_intervalo = (estado_d == DISPARA);

    // The timeout counter is cleared while in dispara, so it reads 0 in the
    // first espera_pronto cycle and reaches TIMEOUT-1 in the TIMEOUT-th one.
    assign zera_timeout  = (estado_q == DISPARA);
    assign conta_timeout = (estado_q == ESPERA_PRONTO);

    contador_m #(.M(INTERVALO)) u_contador_intervalo (
        .clock (clock),
        .reset (reset),
        .zera  (zera_intervalo),
        .conta (1'b1),
        .Q     (q_intervalo_unused),
        .fim   (fim_intervalo)
    );

    contador_m #(.M(TIMEOUT)) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timeout),
        .conta (conta_timeout),
        .Q     (q_timeout_unused),
        .fim   (fim_timeout)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (ligar) estado_d = DISPARA;
            end
            DISPARA: begin
                estado_d = ESPERA_PRONTO;
            end
            ESPERA_PRONTO: begin
                // pronto_sensor wins over a coincident timeout; ligar is not
                // looked at because a sensor cycle in flight cannot be aborted.
                if (sensor.pronto_sensor) begin
                    estado_d = REGISTRA;
                end else if (fim_timeout) begin
                    estado_d = FALHA;
                end
            end
            REGISTRA: begin
                estado_d = ESPERA_INTERVALO;
            end
            FALHA: begin
                estado_d = ESPERA_INTERVALO;
            end
            ESPERA_INTERVALO: begin
                if (!ligar) begin
                    estado_d = INICIAL;
                end else if (fim_intervalo) begin
                    estado_d = DISPARA;
                end
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    always_comb begin
        medida_valida_d = medida_valida_q;
        alerta_d        = alerta_q;
        erro_timeout_d  = erro_timeout_q;
        cont_timeouts_d = cont_timeouts_q;

        // Capture on the same edge that moves into registra, so the new value
        // is already visible while nova_medida is high.
        if (estado_q == ESPERA_PRONTO && sensor.pronto_sensor) begin
            medida_valida_d = sensor.medida;
        end

        if (estado_q == REGISTRA) begin
            erro_timeout_d = 1'b0;
            // Plain unsigned compare orders BCD values correctly.
            if (medida_valida_q < LIMIAR_ON) begin
                alerta_d = 1'b1;
            end else if (medida_valida_q >= LIMIAR_OFF) begin
                alerta_d = 1'b0;
            end
        end

        if (estado_q == FALHA) begin
            erro_timeout_d = 1'b1;
            if (cont_timeouts_q < LIMITE_TIMEOUTS) begin
                cont_timeouts_d = cont_timeouts_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q        <= INICIAL;
            medida_valida_q <= '0;
            alerta_q        <= 1'b0;
            erro_timeout_q  <= 1'b0;
            cont_timeouts_q <= '0;
        end else begin
            estado_q        <= estado_d;
            medida_valida_q <= medida_valida_d;
            alerta_q        <= alerta_d;
            erro_timeout_q  <= erro_timeout_d;
            cont_timeouts_q <= cont_timeouts_d;
        end
    end

    // Moore outputs decoded from the state register only.
    assign sensor.medir = (estado_q == DISPARA);
    assign nova_medida  = (estado_q == REGISTRA);
    assign db_estado    = codigo_db(estado_q);

    assign medida_valida = medida_valida_q;
    assign alerta        = alerta_q;
    assign erro_timeout  = erro_timeout_q;
    assign cont_timeouts = cont_timeouts_q;

endmodule

// File: tb/tb_controle_medicao_hcsr04.sv
// Self-checking bench for controle_medicao_hcsr04 with short timing parameters.
// Expected captures are queued when pronto_sensor is driven and compared when
// the DUT flags nova_medida.
module tb_controle_medicao_hcsr04;

    localparam int INTERVALO = 100;
    localparam int TIMEOUT   = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic [11:0] medida_valida;
    logic        nova_medida;
    logic        alerta;
    logic        erro_timeout;
    logic [3:0]  cont_timeouts;
    logic [3:0]  db_estado;

    controle_medicao_hcsr04_if sensor_if();

    controle_medicao_hcsr04 #(
        .INTERVALO  (INTERVALO),
        .TIMEOUT    (TIMEOUT),
        .LIMIAR_ON  (12'h020),
        .LIMIAR_OFF (12'h025)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .sensor        (sensor_if.master),
        .medida_valida (medida_valida),
        .nova_medida   (nova_medida),
        .alerta        (alerta),
        .erro_timeout  (erro_timeout),
        .cont_timeouts (cont_timeouts),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int          n_checks      = 0;
    int          n_erros       = 0;
    logic [11:0] fila[$];
    logic [11:0] esperado;
    bit          checa_periodo = 1'b0;
    int          ciclo_n       = 0;
    int          ultimo_medir  = -1;
    int          n_falha       = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    // Monitor: medir spacing, falha occupancy and scoreboard pops.
    always @(posedge clock) begin
        #1;
        ciclo_n++;
        if (db_estado == 4'hE) n_falha++;
        if (!checa_periodo) begin
            ultimo_medir = -1;
        end else if (sensor_if.medir) begin
            if (ultimo_medir >= 0) verifica("periodo_medir", ciclo_n - ultimo_medir, INTERVALO);
            ultimo_medir = ciclo_n;
        end
        if (nova_medida) begin
            if (fila.size() == 0) begin
                verifica("nova_medida_inesperada", 32'(nova_medida), 0);
            end else begin
                esperado = fila.pop_front();
                verifica("captura", 32'(medida_valida), 32'(esperado));
            end
        end
    end

    task automatic espera_medir(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * INTERVALO; i++) begin
            ciclo();
            if (sensor_if.medir) begin
                ok = 1'b1;
                break;
            end
        end
        verifica("espera_medir", 32'(sensor_if.medir), 1);
    endtask

    // Called in the dispara cycle; answers after 'atraso' cycles and ends in
    // the first espera_intervalo cycle.
    task automatic responde(input int atraso, input logic [11:0] v);
        repeat (atraso) ciclo();
        verifica("estado_antes_pronto", 32'(db_estado), 2);
        sensor_if.pronto_sensor = 1'b1;
        sensor_if.medida        = v;
        fila.push_back(v);
        ciclo();
        sensor_if.pronto_sensor = 1'b0;
        verifica("nova_medida", 32'(nova_medida), 1);
        ciclo();
    endtask

    task automatic medicao(input int atraso, input logic [11:0] v);
        bit ok;
        espera_medir(ok);
        if (ok) responde(atraso, v);
    endtask

    task automatic verifica_zeros(input string tag);
        verifica({tag, "_medir"},         32'(sensor_if.medir), 0);
        verifica({tag, "_nova_medida"},   32'(nova_medida), 0);
        verifica({tag, "_db_estado"},     32'(db_estado), 0);
        verifica({tag, "_medida_valida"}, 32'(medida_valida), 0);
        verifica({tag, "_alerta"},        32'(alerta), 0);
        verifica({tag, "_erro_timeout"},  32'(erro_timeout), 0);
        verifica({tag, "_cont_timeouts"}, 32'(cont_timeouts), 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulacao nao terminou, observado=travado esperado=fim");
        $fatal(1);
    end

    logic [11:0] amostras [5] = '{12'h030, 12'h019, 12'h022, 12'h025, 12'h022};
    bit          alertas  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        bit ok;
        int n;
        int n0;

        reset                   = 1'b1;
        ligar                   = 1'b0;
        sensor_if.pronto_sensor = 1'b0;
        sensor_if.medida        = 12'h000;
        #1;
        verifica_zeros("reset_inicial");
        repeat (3) ciclo();
        reset = 1'b0;
        ciclo();
        verifica("inicial_db", 32'(db_estado), 0);
        verifica("inicial_medir", 32'(sensor_if.medir), 0);

        // Periodic measurement with a fast sensor.
        checa_periodo = 1'b1;
        ligar         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            medicao(10, 12'h123);
            verifica("t1_nova_um_ciclo", 32'(nova_medida), 0);
            verifica("t1_erro", 32'(erro_timeout), 0);
            verifica("t1_valor", 32'(medida_valida), 32'h123);
        end

        // Alarm hysteresis.
        for (int i = 0; i < 5; i++) begin
            medicao(10, amostras[i]);
            verifica("t3_alerta", 32'(alerta), 32'(alertas[i]));
        end

        // ligar dropped while waiting for the sensor.
        espera_medir(ok);
        repeat (5) ciclo();
        ligar = 1'b0;
        verifica("t4_espera_pronto", 32'(db_estado), 2);
        repeat (5) ciclo();
        sensor_if.pronto_sensor = 1'b1;
        sensor_if.medida        = 12'h321;
        fila.push_back(12'h321);
        ciclo();
        sensor_if.pronto_sensor = 1'b0;
        verifica("t4_nova", 32'(nova_medida), 1);
        ciclo();
        verifica("t4_espera_intervalo", 32'(db_estado), 4);
        ciclo();
        verifica("t4_inicial", 32'(db_estado), 0);
        checa_periodo = 1'b0;
        n = 0;
        repeat (150) begin
            ciclo();
            if (sensor_if.medir) n++;
        end
        verifica("t4_sem_medir", n, 0);
        ligar = 1'b1;
        ciclo();
        verifica("t4_medir_1ciclo", 32'(sensor_if.medir), 1);
        checa_periodo = 1'b1;
        responde(10, 12'h111);

        // pronto coincident with the timeout terminal count, then a stray pronto.
        n0 = n_falha;
        medicao(TIMEOUT, 12'h456);
        verifica("t5_sem_falha", n_falha, n0);
        verifica("t5_erro", 32'(erro_timeout), 0);
        verifica("t5_cont", 32'(cont_timeouts), 0);
        verifica("t5_valor", 32'(medida_valida), 32'h456);
        repeat (10) ciclo();
        sensor_if.pronto_sensor = 1'b1;
        sensor_if.medida        = 12'h999;
        ciclo();
        sensor_if.pronto_sensor = 1'b0;
        repeat (3) ciclo();
        verifica("t5_espurio_valor", 32'(medida_valida), 32'h456);
        verifica("t5_espurio_estado", 32'(db_estado), 4);

        // Repeated timeouts and counter saturation.
        for (int i = 0; i < 20; i++) begin
            espera_medir(ok);
            if (!ok) continue;
            repeat (TIMEOUT) ciclo();
            verifica("t2_ultimo_espera", 32'(db_estado), 2);
            ciclo();
            verifica("t2_db_falha", 32'(db_estado), 32'hE);
            ciclo();
            verifica("t2_falha_1ciclo", 32'(db_estado), 4);
            verifica("t2_erro", 32'(erro_timeout), 1);
            verifica("t2_cont", 32'(cont_timeouts), (i + 1 > 15) ? 15 : i + 1);
        end
        medicao(10, 12'h010);
        verifica("t2_erro_limpo", 32'(erro_timeout), 0);
        verifica("t2_cont_mantido", 32'(cont_timeouts), 15);
        verifica("t2_alerta", 32'(alerta), 1);

        // Asynchronous reset while waiting for the sensor.
        checa_periodo = 1'b0;
        espera_medir(ok);
        repeat (5) ciclo();
        reset = 1'b1;
        #1;
        verifica_zeros("t6_reset");
        repeat (3) begin
            ciclo();
            verifica("t6_medir_em_reset", 32'(sensor_if.medir), 0);
        end
        reset = 1'b0;
        #1;
        verifica("t6_medir_apos_reset", 32'(sensor_if.medir), 0);
        ciclo();
        verifica("t6_medir_1ciclo", 32'(sensor_if.medir), 1);
        verifica("t6_db_dispara", 32'(db_estado), 1);

        ligar = 1'b0;
        repeat (3) ciclo();
        verifica("fila_vazia", fila.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule

// File: doc/controle_medicao_hcsr04.md
Name: controle_medicao_hcsr04

Overview:
Periodic measurement sequencer that sits directly upstream of the HC-SR04 interface.
- Issues one-cycle `medir` requests at a fixed interval while enabled.
- Waits for the interface's `pronto` pulse, or times out if it never arrives.
- Latches the 3-digit BCD distance and flags each new sample.
- Drives a hysteretic proximity alarm and keeps timeout diagnostics for the top level and displays.

Parameters:
- INTERVALO, 5_000_000: clock cycles between consecutive `medir` pulses (100 ms at 50 MHz).
- TIMEOUT, 2_500_000: max cycles to wait for `pronto_sensor` after `medir`. Constraint: TIMEOUT + 4 < INTERVALO.
- LIMIAR_ON, 12'h020: BCD distance (cm); `alerta` sets when the sample is strictly below this.
- LIMIAR_OFF, 12'h025: BCD distance (cm); `alerta` clears when the sample is >= this. Constraint: LIMIAR_ON <= LIMIAR_OFF.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- ligar, input, 1: level enable for periodic measurement.
- pronto_sensor, input, 1: one-cycle pulse from the interface; `medida` is valid in that cycle and after it.
- medida, input, 12: BCD distance from the interface (3 digits).
- medir, output, 1: one-cycle start request to the interface.
- medida_valida, output, 12: last successfully captured BCD distance.
- nova_medida, output, 1: one-cycle pulse when `medida_valida` has just updated.
- alerta, output, 1: proximity alarm with hysteresis.
- erro_timeout, output, 1: high after a timeout; cleared by the next successful capture.
- cont_timeouts, output, 4: saturating timeout count (stops at 15).
- db_estado, output, 4: state code for the 7-segment debug display.

Behaviour:
- Reset: state `inicial`. All outputs 0, including `medida_valida` = 12'h000, `alerta` = 0, `cont_timeouts` = 0. Reset mid-operation aborts immediately; no `medir` is emitted during or on the cycle after reset.
- States and db_estado codes:
  - inicial (0): wait here while `ligar` = 0. If `ligar` = 1, go to dispara.
  - dispara (1): `medir` = 1 for exactly this cycle. Clear the interval counter and the timeout counter. Always go to espera_pronto.
  - espera_pronto (2): timeout counter increments each cycle.
    - If `pronto_sensor` = 1: go to registra and load `medida_valida` <= `medida` on the same edge.
    - Else if timeout counter == TIMEOUT-1: go to falha.
    - `pronto_sensor` wins if it coincides with the timeout terminal count.
    - `ligar` is ignored here, because an in-flight sensor cycle cannot be aborted.
  - registra (3): `nova_medida` = 1 (Moore output, aligned with the updated `medida_valida`). Clear `erro_timeout`. Update `alerta`. Go to espera_intervalo.
  - falha (4'hE): set `erro_timeout` = 1. Increment `cont_timeouts` if below 15. `medida_valida` and `alerta` hold. Go to espera_intervalo.
  - espera_intervalo (4):
    - If `ligar` = 0: go to inicial.
    - Else if interval counter == INTERVALO-1: go to dispara.
  - Any unused encoding: `db_estado` = 4'hF, next state inicial.
- Interval counter:
  - Cleared in dispara; increments every cycle in all other states.
  - Consecutive `medir` pulses are exactly INTERVALO cycles apart while `ligar` stays high.
  - After `ligar` rises in inicial, the first `medir` comes 1 cycle later.
- Alerta update, in registra only, using plain unsigned compare (valid for BCD):
  - If sample < LIMIAR_ON: set 1.
  - Else if sample >= LIMIAR_OFF: clear to 0.
  - Otherwise hold.
- A `pronto_sensor` pulse outside espera_pronto is ignored: no capture, no `nova_medida`.
- All outputs except `medir`, `nova_medida` and `db_estado` are registered. Those three are decoded from the state register only, so they are glitch-free Moore outputs.

Decomposition:
- Shared package holds:
  - state encodings and their db_estado codes;
  - BCD width constant (12);
  - timeout saturation limit (15).
- One natural sub-module: `contador_m` (parameter M; ports `zera`, `conta`, `Q`, `fim`). Instantiate it twice, for the interval counter and the timeout counter.
- FSM, capture register and alarm logic stay in this module.

Test Plan:
Bench parameters: INTERVALO=100, TIMEOUT=40, LIMIAR_ON=12'h020, LIMIAR_OFF=12'h025.
1. Raise `ligar`; `pronto_sensor` pulses 10 cycles after each `medir` with `medida`=12'h123 → `medir` pulses exactly 100 cycles apart. `medida_valida`=12'h123 and `nova_medida` high in the same single cycle; `erro_timeout`=0.
2. Never assert `pronto_sensor` → after 40 cycles in espera_pronto, `db_estado`=4'hE for 1 cycle, `erro_timeout`=1 and `cont_timeouts` increments. After 20 consecutive timeouts, `cont_timeouts` stays 15. Then a valid `pronto` clears `erro_timeout`, but `cont_timeouts` remains 15.
3. Sample sequence 12'h030, 12'h019, 12'h022, 12'h025, 12'h022 → `alerta` = 0, 1, 1, 0, 0.
4. Drop `ligar` during espera_pronto → measurement still completes with a capture, then FSM returns to inicial and no further `medir` is issued. Re-raise `ligar` → `medir` appears 1 cycle later.
5. Assert `pronto_sensor` on the same cycle the timeout counter hits 39 → capture taken, no timeout counted. A stray `pronto_sensor` in espera_intervalo → no change to `medida_valida`.
6. Assert `reset` in espera_pronto → all outputs 0 asynchronously and state `inicial`. After release with `ligar`=1, `medir` appears 1 cycle later.
